// File: rtl/m_stage_dmem_if.sv
// M-stage data memory bus: E->M register outputs in, load data and error record out.
// master = pipeline side driving the access, slave = the data memory.
interface m_stage_dmem_if;
  logic [31:0] alu_out_m;   // effective byte address
  logic [31:0] data2_m;     // store data (rt)
  logic [31:0] ir_m;        // M-stage instruction word
  logic [31:0] pc_m;        // M-stage instruction address
  logic [31:0] rdata_m;     // extended load result
  logic        adel;        // load address error (combinational)
  logic        ades;        // store address error (combinational)
  logic        err_sticky;  // first fault seen since reset
  logic [31:0] err_pc;      // pc of first fault
  logic [31:0] err_addr;    // address of first fault

  modport master (
    output alu_out_m,
    output data2_m,
    output ir_m,
    output pc_m,
    input  rdata_m,
    input  adel,
    input  ades,
    input  err_sticky,
    input  err_pc,
    input  err_addr
  );

  modport slave (
    input  alu_out_m,
    input  data2_m,
    input  ir_m,
    input  pc_m,
    output rdata_m,
    output adel,
    output ades,
    output err_sticky,
    output err_pc,
    output err_addr
  );
endinterface

// File: rtl/m_stage_dmem.sv
// Memory-stage data memory for the 5-stage MIPS pipeline.
// Combinational reads with sign/zero extension, byte-enabled writes at posedge clk,
// and a sticky record of the first misaligned or out-of-range access.
// Optional feature: define DMEM_TRACE_EN to print every committed store.
module m_stage_dmem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = 12
) (
  input logic           clk,
  input logic           reset,  // asynchronous, active-low
  m_stage_dmem_if.slave bus
);

  // Opcodes of the supported loads and stores
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  // One past the last valid byte address; 33 bits so large depths cannot wrap
  localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        r_err_sticky;
  logic [31:0] r_err_pc;
  logic [31:0] r_err_addr;

  logic [5:0]        w_op;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_signed;
  size_e             w_size;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic              w_in_range;
  logic              w_misalign;
  logic              w_fault;
  logic              w_adel;
  logic              w_ades;
  logic              w_we;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_rdata;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_merged;

  assign w_op  = bus.ir_m[31:26];
  assign w_idx = bus.alu_out_m[ADDR_W+1:2];
  assign w_off = bus.alu_out_m[1:0];

  // Opcode decode: access kind, size and extension
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = SzWord;
    unique case (w_op)
      OpLw: begin
        w_is_load = 1'b1;
        w_size    = SzWord;
      end
      OpLh: begin
        w_is_load = 1'b1;
        w_size    = SzHalf;
        w_signed  = 1'b1;
      end
      OpLhu: begin
        w_is_load = 1'b1;
        w_size    = SzHalf;
      end
      OpLb: begin
        w_is_load = 1'b1;
        w_size    = SzByte;
        w_signed  = 1'b1;
      end
      OpLbu: begin
        w_is_load = 1'b1;
        w_size    = SzByte;
      end
      OpSw: begin
        w_is_store = 1'b1;
        w_size     = SzWord;
      end
      OpSh: begin
        w_is_store = 1'b1;
        w_size     = SzHalf;
      end
      OpSb: begin
        w_is_store = 1'b1;
        w_size     = SzByte;
      end
      default: begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
      end
    endcase
  end

  // Address checks: range and natural alignment for the access size
  always_comb begin
    w_in_range = ({1'b0, bus.alu_out_m} < ByteLimit);
    w_misalign = 1'b0;
    case (w_size)
      SzWord:  w_misalign = (w_off != 2'b00);
      SzHalf:  w_misalign = w_off[0];
      default: w_misalign = 1'b0;
    endcase
    w_fault = !w_in_range || w_misalign;
    w_adel  = w_is_load && w_fault;
    w_ades  = w_is_store && w_fault;
    w_we    = w_is_store && !w_fault;
  end

  // Out-of-range addresses alias into the array here, but their results are discarded
  assign w_word = r_mem[w_idx];

  // Load path: lane select then sign/zero extension; faults and non-loads read 0
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    w_rdata = 32'h0;
    case (w_off)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    if (w_is_load && !w_fault) begin
      case (w_size)
        SzByte:  w_rdata = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
        SzHalf:  w_rdata = w_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        default: w_rdata = w_word;
      endcase
    end
  end

  // Store path: byte enables plus lane-replicated data, merged over the current word
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.data2_m;
    case (w_size)
      SzByte: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{bus.data2_m[7:0]}};
      end
      SzHalf: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.data2_m[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.data2_m;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      w_merged[8*k +: 8] = w_be[k] ? w_wdata[8*k +: 8] : w_word[8*k +: 8];
    end
  end

  // Memory array: reset clears every word, otherwise commit non-faulting stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i[ADDR_W-1:0]] <= 32'h0;
      end
    end else if (w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Error latch: capture only the first faulting access after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_sticky <= 1'b0;
      r_err_pc     <= 32'h0;
      r_err_addr   <= 32'h0;
    end else if (!r_err_sticky && (w_adel || w_ades)) begin
      r_err_sticky <= 1'b1;
      r_err_pc     <= bus.pc_m;
      r_err_addr   <= bus.alu_out_m;
    end
  end

`ifdef DMEM_TRACE_EN
  logic [31:0] w_word_addr;
  assign w_word_addr = {bus.alu_out_m[31:2], 2'b00};

  // Store trace: one line per committed store with the full post-write word
  always_ff @(posedge clk) begin
    if (reset && w_we) begin
      $display("%d@%h: *%h <= %h", $time, bus.pc_m, w_word_addr, w_merged);
    end
  end
`endif

  assign bus.rdata_m    = w_rdata;
  assign bus.adel       = w_adel;
  assign bus.ades       = w_ades;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_pc     = r_err_pc;
  assign bus.err_addr   = r_err_addr;

endmodule
